shiftreg_seq_ctrl: RTL and testbench

- Sequencer for the 8-stage serial shift-register datapath.
- Accepts a parallel word through a valid/ready handshake and drives it out serially, one bit per cycle, with a shift-enable strobe.
- Simultaneously captures the returning serial stream into a parallel result, which it presents with a valid/ready handshake.
- Sits between a parallel producer/consumer and the serial shift chain; it owns the bit count and the shift timing.

---
 rtl/shiftreg_seq_pkg.sv | 20 ++
 rtl/shiftreg_seq_ctrl_if.sv | 29 ++
 rtl/shiftreg_seq_dp.sv | 62 ++++++
 rtl/shiftreg_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_shiftreg_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shiftreg_seq_pkg.sv
// Shared types and sizing helpers for the serial shift-register sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shiftreg_seq_pkg;

    // Controller states; the top-level module mirrors these as 2-bit constants
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The bit counter must be able to hold WIDTH itself so it never wraps mid-transfer
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftreg_seq_ctrl_if.sv
// Parallel-in/parallel-out handshakes plus the serial chain pins of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: din_ready / dout_ready carry the two valid-ready handshakes.
interface shiftreg_seq_ctrl_if #(
    parameter int WIDTH = shiftreg_seq_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             shift_en;
    logic             ser_in;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    // Controller side
    modport slave (
        input  din, din_valid, ser_in, dout_ready,
        output din_ready, ser_out, shift_en, busy, dout, dout_valid
    );

    // Producer / consumer / chain side
    modport master (
        output din, din_valid, ser_in, dout_ready,
        input  din_ready, ser_out, shift_en, busy, dout, dout_valid
    );
endinterface

// File: rtl/shiftreg_seq_dp.sv
// Transmit/receive shift registers and result register for the sequencer.
// Latency: tx_bit_nxt is combinational from the next tx value; dout updates on the capture edge.
// Backpressure: none here; the controller only strobes load/shift/capture when allowed.
module shiftreg_seq_dp #(
    parameter int   WIDTH     = shiftreg_seq_pkg::DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             capture,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    output logic             tx_bit_nxt,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    // Next-state of the shift registers; transmit end and capture end swap with bit order
    always_comb begin
        tx_d   = tx_q;
        rx_d   = rx_q;
        dout_d = dout_q;
        if (load) begin
            tx_d = din;
            rx_d = '0;
        end else if (shift) begin
            if (MSB_FIRST) begin
                tx_d = {tx_q[WIDTH-2:0], 1'b0};
                rx_d = {rx_q[WIDTH-2:0], ser_in};
            end else begin
                tx_d = {1'b0, tx_q[WIDTH-1:1]};
                rx_d = {ser_in, rx_q[WIDTH-1:1]};
            end
            // The final bit is folded in on the same edge the result is latched
            if (capture) begin
                dout_d = rx_d;
            end
        end
        // Bit that will sit at the transmit end after this edge; lets ser_out be a flop
        tx_bit_nxt = MSB_FIRST ? tx_d[WIDTH-1] : tx_d[0];
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            dout_q <= '0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer: takes a parallel word, shifts it out one bit per cycle while capturing the return stream.
// Latency: accept at edge N, first serial bit in cycle N+1, dout_valid in cycle N+WIDTH+1.
// Backpressure: din_ready only in IDLE; a held DONE (dout_ready=0) blocks new words indefinitely.
module shiftreg_seq_ctrl
    import shiftreg_seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    shiftreg_seq_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             din_ready_q, din_ready_d;
    logic             dout_valid_q, dout_valid_d;

    logic             load;
    logic             shift;
    logic             capture;
    logic             tx_bit_nxt;
    logic [WIDTH-1:0] dout_w;

    // FSM and bit counter; all outputs are decoded from the next state so they leave a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.din_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A word offered in the same cycle waits for the following IDLE cycle
                if (bus.dout_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ser_out_d    = (state_d == S_SHIFT) ? tx_bit_nxt : IDLE_LVL;
        shift_en_d   = (state_d == S_SHIFT);
        busy_d       = (state_d != S_IDLE);
        din_ready_d  = (state_d == S_IDLE);
        dout_valid_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ser_out_q    <= IDLE_LVL;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            din_ready_q  <= 1'b1;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    shiftreg_seq_dp #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift      (shift),
        .capture    (capture),
        .din        (bus.din),
        .ser_in     (bus.ser_in),
        .tx_bit_nxt (tx_bit_nxt),
        .dout       (dout_w)
    );

    assign bus.ser_out    = ser_out_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.busy       = busy_q;
    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_w;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl: an MSB-first and an LSB-first instance run in lockstep on shared stimulus.
// Latency: expectations are scheduled from the accept cycle (bits at +1..+W, result at +W+1).
// Backpressure: dout_ready is driven directly or randomly; a monitor checks every cycle.
module tb_shiftreg_seq_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] din;
    logic         din_valid;
    logic         ser_drv;
    logic         loop;
    logic         rdy_dir;
    logic         rdy_rand;
    logic         rand_rdy;
    logic         dout_ready;
    assign dout_ready = rand_rdy ? rdy_rand : rdy_dir;

    shiftreg_seq_ctrl_if #(.WIDTH(W)) bus_m ();
    shiftreg_seq_ctrl_if #(.WIDTH(W)) bus_l ();

    assign bus_m.din        = din;
    assign bus_m.din_valid  = din_valid;
    assign bus_m.dout_ready = dout_ready;
    assign bus_m.ser_in     = loop ? bus_m.ser_out : ser_drv;
    assign bus_l.din        = din;
    assign bus_l.din_valid  = din_valid;
    assign bus_l.dout_ready = dout_ready;
    assign bus_l.ser_in     = loop ? bus_l.ser_out : ser_drv;

    shiftreg_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_m (
        .clk (clk), .rst (rst), .bus (bus_m)
    );
    shiftreg_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_l (
        .clk (clk), .rst (rst), .bus (bus_l)
    );

    // index 0 = MSB-first instance, index 1 = LSB-first instance
    logic [1:0]   so, se, bz, dr, dv;
    logic [W-1:0] dq0, dq1;
    assign so  = {bus_l.ser_out,    bus_m.ser_out};
    assign se  = {bus_l.shift_en,   bus_m.shift_en};
    assign bz  = {bus_l.busy,       bus_m.busy};
    assign dr  = {bus_l.din_ready,  bus_m.din_ready};
    assign dv  = {bus_l.dout_valid, bus_m.dout_valid};
    assign dq0 = bus_m.dout;
    assign dq1 = bus_l.dout;

    typedef struct { int c; logic [1:0] b; } bit_t;
    typedef struct { int due; logic [W-1:0] d0; logic [W-1:0] d1; } res_t;
    bit_t qb[$];
    res_t qr[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    bit seen   = 1'b0;
    int last_hs = -1;
    logic [W-1:0] last_d0 = '0;
    logic [W-1:0] last_d1 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the serial stream seen at ser_in is either the transmitted word in
    // transmit order (loopback) or rp MSB-first in time; MSB-first capture puts the first
    // received bit at dout[W-1], LSB-first capture puts it at dout[0].
    task automatic push_exp(input logic [W-1:0] w, input logic [W-1:0] rp, input bit lp, input int acc);
        logic [W-1:0] sm, sl, e0, e1;
        for (int i = 0; i < W; i++) begin
            sm[i] = lp ? w[W-1-i] : rp[W-1-i];
            sl[i] = lp ? w[i]     : rp[W-1-i];
        end
        for (int i = 0; i < W; i++) begin
            qb.push_back('{acc + 1 + i, {w[i], w[W-1-i]}});
            e0[W-1-i] = sm[i];
            e1[i]     = sl[i];
        end
        qr.push_back('{acc + W + 1, e0, e1});
    endtask

    task automatic wait_accept(output int acc);
        acc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (dr == 2'b11) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that ends the shift
    task automatic send(input logic [W-1:0] w, input logic [W-1:0] rp, input bit lp, output int acc);
        din       = w;
        din_valid = 1'b1;
        loop      = lp;
        wait_accept(acc);
        if (acc >= 0) push_exp(w, rp, lp, acc);
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = W'($urandom);
        for (int i = 0; i < W; i++) begin
            ser_drv = rp[W-1-i];
            @(posedge clk); #1;
        end
        ser_drv = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (qr.size() == 0 && qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        chk("dout_held_m", 32'(dq0), 32'(last_d0));
        chk("dout_held_l", 32'(dq1), 32'(last_d1));
        @(posedge clk); #1;
    endtask

    // Monitor: serial pins and result handshake checked every cycle against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (qb.size() > 0 && qb[0].c == cyc) begin
                    for (int i = 0; i < 2; i++) begin
                        chk("shift_en_on", 32'(se[i]), 32'd1);
                        chk("ser_out_bit", 32'(so[i]), 32'(qb[0].b[i]));
                    end
                    void'(qb.pop_front());
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        chk("shift_en_off", 32'(se[i]), 32'd0);
                        chk("ser_out_idle", 32'(so[i]), 32'd1);
                    end
                end
                if (dv != 2'b00) begin
                    if (qr.size() == 0) begin
                        chk("dout_valid_unexpected", 32'(dv), 32'd0);
                    end else begin
                        if (!seen) begin
                            chk("dout_valid_latency", 32'(cyc), 32'(qr[0].due));
                            seen = 1'b1;
                        end
                        chk("dout_valid_both", 32'(dv), 32'd3);
                        chk("dout_m", 32'(dq0), 32'(qr[0].d0));
                        chk("dout_l", 32'(dq1), 32'(qr[0].d1));
                        chk("din_ready_in_done", 32'(dr), 32'd0);
                        chk("busy_in_done", 32'(bz), 32'd3);
                        if (dout_ready) begin
                            last_hs = cyc;
                            last_d0 = qr[0].d0;
                            last_d1 = qr[0].d1;
                            seen    = 1'b0;
                            void'(qr.pop_front());
                        end
                    end
                end else if (qr.size() > 0 && cyc >= qr[0].due) begin
                    chk("dout_valid_missing", 32'(dv), 32'd3);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        ser_drv   = 1'b0;
        loop      = 1'b1;
        rdy_dir   = 1'b1;
        rdy_rand  = 1'b1;
        rand_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_din_ready", 32'(dr), 32'd3);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_shift_en", 32'(se), 32'd0);
        chk("rst_ser_out", 32'(so), 32'd3);
        chk("rst_dout_valid", 32'(dv), 32'd0);
        chk("rst_dout_m", 32'(dq0), 32'd0);
        chk("rst_dout_l", 32'(dq1), 32'd0);
        mon_en = 1'b1;

        // Idle for 20 cycles with no din_valid
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ser_out", 32'(so), 32'd3);
            chk("idle_shift_en", 32'(se), 32'd0);
            chk("idle_busy", 32'(bz), 32'd0);
            chk("idle_din_ready", 32'(dr), 32'd3);
        end
        @(posedge clk); #1;

        // Loopback A5
        send(8'hA5, W'($urandom), 1'b1, a1);
        wait_idle();

        // 01 with ser_in held high
        send(8'h01, 8'hFF, 1'b0, a1);
        wait_idle();

        // Backpressure: result held 5 cycles while 3C waits on din
        rdy_dir = 1'b0;
        send(W'($urandom), W'($urandom), 1'b1, a1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 rdy_dir = 1'b1;
            end
            begin
                send(8'h3C, W'($urandom), 1'b1, a2);
            end
        join
        chk("accept_after_release", 32'(a2), 32'(last_hs + 1));
        wait_idle();

        // Reset in cycle 4 of an F0 transfer
        din       = 8'hF0;
        din_valid = 1'b1;
        loop      = 1'b1;
        wait_accept(a1);
        if (a1 >= 0) push_exp(8'hF0, 8'h00, 1'b1, a1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qb.delete();
        qr.delete();
        seen = 1'b0;
        @(negedge clk);
        chk("abort_shift_en", 32'(se), 32'd0);
        chk("abort_ser_out", 32'(so), 32'd3);
        chk("abort_dout_valid", 32'(dv), 32'd0);
        chk("abort_dout_m", 32'(dq0), 32'd0);
        chk("abort_dout_l", 32'(dq1), 32'd0);
        chk("abort_busy", 32'(bz), 32'd0);
        chk("abort_din_ready", 32'(dr), 32'd3);
        repeat (12) @(posedge clk);
        #1;
        send(8'h5A, W'($urandom), 1'b1, a1);
        wait_idle();

        // Back-to-back loopback
        rdy_dir = 1'b1;
        send(8'h00, W'($urandom), 1'b1, a1);
        send(8'hFF, W'($urandom), 1'b1, a2);
        send(8'h81, W'($urandom), 1'b1, a3);
        chk("b2b_spacing_1", 32'(a2 - a1), 32'(W + 2));
        chk("b2b_spacing_2", 32'(a3 - a2), 32'(W + 2));
        wait_idle();

        // Random words, random return stream, random consumer stalls
        rand_rdy = 1'b1;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), a1);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 600; k++) begin
                    @(posedge clk); #1;
                    rdy_rand = ($urandom_range(0, 3) != 0);
                end
            end
        join_any
        wait_idle();
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
